// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - Register file bus bundle: two read ports, two write ports, reserve port, scoreboard vector.
interface regfile_mp_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic            rs1_en;
  logic [AW-1:0]   rs1_addr;
  logic [XLEN-1:0] rs1_data;
  logic            rs1_busy;

  logic            rs2_en;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs2_data;
  logic            rs2_busy;

  logic            wr0_en;
  logic [AW-1:0]   wr0_addr;
  logic [XLEN-1:0] wr0_data;

  logic            wr1_en;
  logic [AW-1:0]   wr1_addr;
  logic [XLEN-1:0] wr1_data;

  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;

  logic [NREG-1:0] busy_vec;

  modport master (
    output rs1_en, rs1_addr, rs2_en, rs2_addr,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output rsv_en, rsv_addr,
    input  rs1_data, rs1_busy, rs2_data, rs2_busy, busy_vec
  );

  modport slave (
    input  rs1_en, rs1_addr, rs2_en, rs2_addr,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  rsv_en, rsv_addr,
    output rs1_data, rs1_busy, rs2_data, rs2_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 2R/2W register file with per-register pending scoreboard; x0 hardwired to zero.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int AW = $clog2(NREG);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;

  logic wr0_ok;
  logic wr1_ok;
  logic rsv_ok;

  // Requests are qualified by rst so nothing leaks through the bypass while in reset.
  assign wr0_ok = bus.wr0_en && rst && (bus.wr0_addr != '0);
  assign wr1_ok = bus.wr1_en && rst && (bus.wr1_addr != '0);
  assign rsv_ok = bus.rsv_en && rst && (bus.rsv_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs[0]   <= '0;
      busy_q[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (wr1_ok && (bus.wr1_addr == AW'(i))) begin
          regs[i] <= bus.wr1_data;
        end else if (wr0_ok && (bus.wr0_addr == AW'(i))) begin
          regs[i] <= bus.wr0_data;
        end
        // A new reservation outranks the completing write: the new producer is still pending.
        if (rsv_ok && (bus.rsv_addr == AW'(i))) begin
          busy_q[i] <= 1'b1;
        end else if ((wr0_ok && (bus.wr0_addr == AW'(i))) ||
                     (wr1_ok && (bus.wr1_addr == AW'(i)))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.busy_vec = busy_q;

  logic [1:0]         rd_en;
  logic [1:0][AW-1:0] rd_addr;

  assign rd_en   = {bus.rs2_en, bus.rs1_en};
  assign rd_addr = {bus.rs2_addr, bus.rs1_addr};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [XLEN-1:0] data;
    logic            busy;
    logic            hit0;
    logic            hit1;

    assign hit0 = wr0_ok && (bus.wr0_addr == rd_addr[p]);
    assign hit1 = wr1_ok && (bus.wr1_addr == rd_addr[p]);

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (rd_en[p] && (rd_addr[p] != '0)) begin
        data = regs[rd_addr[p]];
        busy = busy_q[rd_addr[p]];
        if (BYPASS && (hit0 || hit1)) begin
          data = hit1 ? bus.wr1_data : bus.wr0_data;
          busy = rsv_ok && (bus.rsv_addr == rd_addr[p]);
        end
      end
    end
  end

  assign bus.rs1_data = g_rd[0].data;
  assign bus.rs1_busy = g_rd[0].busy;
  assign bus.rs2_data = g_rd[1].data;
  assign bus.rs2_busy = g_rd[1].busy;
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of every register.
REQ-002 SHALL have parameter NREG, default 32, register count, power of two, at least 2.
REQ-003 SHALL have localparam AW = $clog2(NREG), address width; not overridable.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports rs1_en/rs2_en, input, 1, read-port enables.
REQ-007 SHALL have ports rs1_addr/rs2_addr, input, AW, read addresses.
REQ-008 SHALL have ports rs1_data/rs2_data, output, XLEN, read data.
REQ-009 SHALL have ports rs1_busy/rs2_busy, output, 1, scoreboard busy for the addressed register.
REQ-010 SHALL have ports wr0_en/wr1_en, input, 1, write-port enables.
REQ-011 SHALL have ports wr0_addr/wr1_addr, input, AW, write addresses.
REQ-012 SHALL have ports wr0_data/wr1_data, input, XLEN, write data.
REQ-013 SHALL have port rsv_en, input, 1, reserve request: mark a destination pending.
REQ-014 SHALL have port rsv_addr, input, AW, register to reserve.
REQ-015 SHALL have port busy_vec, output, NREG, registered scoreboard bits; bit 0 always 0.

Function
REQ-016 SHALL read combinationally: rsN_data = regs[rsN_addr] when rsN_en=1 and rsN_addr!=0, else 0.
REQ-017 SHALL drive rsN_busy = busy_vec[rsN_addr] when rsN_en=1, else 0.
REQ-018 SHALL make register 0 read 0 and never busy; writes and reserves to address 0 SHALL be discarded.
REQ-019 SHALL write regs[wrN_addr] <= wrN_data at the clock edge when wrN_en=1 and wrN_addr!=0; no other register changes.
REQ-020 SHALL store only wr1_data when both ports write the same nonzero address in one cycle (port 1 priority).
REQ-021 SHALL set busy_vec[rsv_addr] at the clock edge when rsv_en=1 and rsv_addr!=0.
REQ-022 SHALL clear busy_vec[a] at the clock edge when any enabled write targets a, unless the same cycle reserves a.
REQ-023 SHALL keep busy set when a reserve and a write hit the same address in one cycle (reserve wins; the new producer is pending).
REQ-024 SHALL let writes to a non-busy register proceed normally, with no error and busy left at 0.
REQ-025 SHALL leave unwritten, unreserved registers unchanged every cycle; disabled ports SHALL not store anything.

Reset
REQ-026 SHALL, with rst=0, clear all regs to 0 and busy_vec to 0 asynchronously, independent of clk.
REQ-027 SHALL hold rsN_data=0 and rsN_busy=0 during reset, since storage is 0.
REQ-028 SHALL discard all write and reserve requests while rst=0, including any coinciding with reset assertion mid-operation.
REQ-029 SHALL resume normal operation at the first rising clk edge after rst returns to 1.

Configuration
REQ-030 SHALL add write-to-read bypass when macro REGFILE_BYPASS_EN is defined: a read of address a with a same-cycle enabled write to a (a!=0) SHALL return that write data (wr1 over wr0), and rsN_busy SHALL be 0 unless rsv_en=1 with rsv_addr=a.
REQ-031 SHALL, when REGFILE_BYPASS_EN is undefined, return the stored value and the registered busy bit; written data SHALL be visible from the cycle after the edge.

Verification
REQ-032 SHALL cover: reset, then wr0 x5=0x1234 -> next cycle rs1_addr=5 returns 0x1234; rs2_addr=0 returns 0.
REQ-033 SHALL cover: same cycle wr0 x7=0xAA, wr1 x7=0xBB -> x7 reads 0xBB.
REQ-034 SHALL cover: rsv x9 -> busy_vec[9]=1 and rs1_busy=1; wr1 x9=0x55 -> busy clears, reads 0x55; reserve plus write of x9 in one cycle -> busy stays 1.
REQ-035 SHALL cover: wr0 x0=0xFF and rsv x0 -> x0 reads 0 and busy_vec[0]=0.
REQ-036 SHALL cover: with REGFILE_BYPASS_EN, reserved x3 with wr0 x3=0x77 -> same cycle rs1_data=0x77, rs1_busy=0; without the macro -> old value and busy=1 that cycle.
REQ-037 SHALL cover: after x5 and x9 are written and reserved, assert rst=0 between clock edges -> all reads 0 and busy_vec=0 immediately; a write held during reset is lost.
